ads5296_tx_emulator: RTL and testbench

//  Emulates one ADS5296 ADC unit's LVDS output at the lclk_d4 (line clock / 4) deserialized level.

---
 rtl/ads5296_tx_emulator.sv | 173 +++++++++++++++++
 tb/tb_ads5296_tx_emulator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ads5296_tx_emulator.sv
// ADS5296 LVDS transmit emulator at the lclk_d4 deserialized level: a 5-phase frame clock
// plus two interleaved 10-bit LSB-first lanes, emitted as 4-bit chunks.
module ads5296_tx_emulator #(
  parameter logic [9:0] CONST_WORD = 10'h2A5,
  parameter logic [9:0] IDLE_WORD  = 10'h000
) (
  input  logic        lclk_d4,
  input  logic        rst,
  input  logic        en,
  input  logic        sync,
  input  logic [1:0]  mode,
  input  logic [1:0]  bit_shift,
  input  logic        inject_fclk_err,
  input  logic [19:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  fclk4b,
  output logic [7:0]  din4b,
  output logic [31:0] underflow_cnt
);
  localparam int unsigned WORD_W  = 10;
  localparam int unsigned CHUNK_W = 4;
  localparam logic [WORD_W-1:0] DESKEW_WORD = 10'h155;
  localparam logic [1:0] MODE_STREAM = 2'd0;
  localparam logic [1:0] MODE_RAMP   = 2'd1;
  localparam logic [1:0] MODE_CONST  = 2'd2;

  typedef enum logic [2:0] {P0, P1, P2, P3, P4} phase_t;

  phase_t phase_q, phase_d;
  logic [WORD_W-1:0]  w0_l0, w0_l1, w1_l0, w1_l1, ramp_q;
  logic [WORD_W-1:0]  src0_c, src1_c;
  logic [CHUNK_W-1:0] fclk_c, chunk0_c, chunk1_c;
  logic [CHUNK_W-1:0] a_fclk, a_d0, a_d1, ap_fclk, ap_d0, ap_d1;
  logic [CHUNK_W-1:0] sh_fclk_c, sh_d0_c, sh_d1_c;
  logic [2:0]         rshift_c;
  logic               slot_c, cap_w0_c, cap_w1_c;

  // Slice one chunk of the 20-bit frame {w1, w0} for the given phase
  function automatic logic [CHUNK_W-1:0] data_chunk(input logic [WORD_W-1:0] w0,
                                                     input logic [WORD_W-1:0] w1,
                                                     input phase_t p);
    logic [CHUNK_W-1:0] c;
    case (p)
      P0:      c = w0[3:0];
      P1:      c = w0[7:4];
      P2:      c = {w1[1:0], w0[9:8]};
      P3:      c = w1[5:2];
      default: c = w1[9:6];
    endcase
    return c;
  endfunction

  always_ff @(posedge lclk_d4) begin
    if (rst) phase_q <= P0;
    else     phase_q <= phase_d;
  end

  // sync forces P0 even when en is low
  always_comb begin
    phase_d = phase_q;
    if (sync) begin
      phase_d = P0;
    end else if (en) begin
      case (phase_q)
        P0:      phase_d = P1;
        P1:      phase_d = P2;
        P2:      phase_d = P3;
        P3:      phase_d = P4;
        default: phase_d = P0;
      endcase
    end
  end

  assign slot_c   = en & ~sync & ((phase_q == P1) | (phase_q == P4));
  assign in_ready = slot_c & (mode == MODE_STREAM);
  assign cap_w0_c = sync | (slot_c & (phase_q == P4));
  assign cap_w1_c = sync | (slot_c & (phase_q == P1));

  // Word source for the next capture; a sync in stream mode falls through to IDLE_WORD
  always_comb begin
    src0_c = DESKEW_WORD;
    src1_c = DESKEW_WORD;
    case (mode)
      MODE_STREAM: begin
        src0_c = (in_ready & in_valid) ? in_data[9:0]   : IDLE_WORD;
        src1_c = (in_ready & in_valid) ? in_data[19:10] : IDLE_WORD;
      end
      MODE_RAMP: begin
        src0_c = ramp_q;
        src1_c = ~ramp_q;
      end
      MODE_CONST: begin
        src0_c = CONST_WORD;
        src1_c = CONST_WORD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge lclk_d4) begin
    if (rst) begin
      w0_l0         <= '0;
      w0_l1         <= '0;
      w1_l0         <= '0;
      w1_l1         <= '0;
      ramp_q        <= '0;
      underflow_cnt <= '0;
    end else begin
      if (cap_w0_c) begin
        w0_l0 <= src0_c;
        w0_l1 <= src1_c;
      end
      if (cap_w1_c) begin
        w1_l0 <= src0_c;
        w1_l1 <= src1_c;
      end
      if (sync)                             ramp_q <= '0;
      else if (slot_c && mode == MODE_RAMP) ramp_q <= ramp_q + 10'd1;
      if ((in_ready & ~in_valid) | (sync & (mode == MODE_STREAM)))
        underflow_cnt <= underflow_cnt + 32'd1;
    end
  end

  always_comb begin
    fclk_c = 4'b0000;
    case (phase_q)
      P0:      fclk_c = 4'b1111;
      P1:      fclk_c = 4'b0001;
      P2:      fclk_c = 4'b1100;
      P3:      fclk_c = 4'b0111;
      default: fclk_c = 4'b0000;
    endcase
    chunk0_c = data_chunk(w0_l0, w1_l0, phase_q);
    chunk1_c = data_chunk(w0_l1, w1_l1, phase_q);
  end

  // Stage A: current chunk (zeroed while disabled), plus previous chunk for the shifter
  always_ff @(posedge lclk_d4) begin
    if (rst) begin
      a_fclk  <= '0;
      a_d0    <= '0;
      a_d1    <= '0;
      ap_fclk <= '0;
      ap_d0   <= '0;
      ap_d1   <= '0;
    end else begin
      a_fclk  <= en ? (fclk_c ^ {3'b000, inject_fclk_err}) : 4'b0000;
      a_d0    <= en ? chunk0_c : 4'b0000;
      a_d1    <= en ? chunk1_c : 4'b0000;
      ap_fclk <= a_fclk;
      ap_d0   <= a_d0;
      ap_d1   <= a_d1;
    end
  end

  assign rshift_c  = 3'd4 - 3'(bit_shift);
  assign sh_fclk_c = 4'({a_fclk, ap_fclk} >> rshift_c);
  assign sh_d0_c   = 4'({a_d0, ap_d0} >> rshift_c);
  assign sh_d1_c   = 4'({a_d1, ap_d1} >> rshift_c);

  // Stage B: bit-phase shift; forced to 0 the cycle after en drops
  always_ff @(posedge lclk_d4) begin
    if (rst) begin
      fclk4b <= '0;
      din4b  <= '0;
    end else begin
      fclk4b <= en ? sh_fclk_c : 4'b0000;
      din4b  <= en ? {sh_d1_c, sh_d0_c} : 8'h00;
    end
  end

endmodule

// File: tb/tb_ads5296_tx_emulator.sv
// Bench for ads5296_tx_emulator: directed steps plus randomized traffic against a
// frame/bitstream-level reference model.
module tb_ads5296_tx_emulator;
  localparam logic [9:0] CONST_W  = 10'h2A5;
  localparam logic [9:0] IDLE_W   = 10'h000;
  localparam logic [9:0] DESKEW_W = 10'h155;
  localparam int         FCLK_FRAME = 32'h0007C1F;  // fclk high on serial bits 0-4 and 10-14

  logic        clk = 1'b0;
  logic        rst, en, sync, inj, in_valid;
  logic [1:0]  mode, bs;
  logic [19:0] in_data;
  logic        in_ready;
  logic [3:0]  fclk4b;
  logic [7:0]  din4b;
  logic [31:0] underflow_cnt;

  always #5 clk = ~clk;

  ads5296_tx_emulator dut (
    .lclk_d4        (clk),
    .rst            (rst),
    .en             (en),
    .sync           (sync),
    .mode           (mode),
    .bit_shift      (bs),
    .inject_fclk_err(inj),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .fclk4b         (fclk4b),
    .din4b          (din4b),
    .underflow_cnt  (underflow_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: frame words per lane, serial chunk history, counters
  int         m_phase = 0;
  int         m_ramp  = 0;
  logic [9:0] m_w0[2] = '{10'h0, 10'h0};
  logic [9:0] m_w1[2] = '{10'h0, 10'h0};
  int         m_uf    = 0;
  int         m_a[3]   = '{0, 0, 0};
  int         m_ap[3]  = '{0, 0, 0};
  int         m_out[3] = '{0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_ready();
    return en && !sync && mode == 2'd0 && (m_phase == 1 || m_phase == 4);
  endfunction

  // Serial view: output chunk is the 4-bit window taken bit_shift bits earlier in the stream
  function automatic int window(input int cur, input int prev, input int shift);
    return (((cur << 4) | prev) >> (4 - shift)) & 15;
  endfunction

  task automatic model_step();
    logic       rdy;
    logic [9:0] s[2];
    int         ch[3];
    if (rst) begin
      m_phase = 0; m_ramp = 0; m_uf = 0;
      m_w0 = '{10'h0, 10'h0}; m_w1 = '{10'h0, 10'h0};
      m_a = '{0, 0, 0}; m_ap = '{0, 0, 0}; m_out = '{0, 0, 0};
      return;
    end
    rdy = model_ready();
    for (int k = 0; k < 3; k++) m_out[k] = en ? window(m_a[k], m_ap[k], int'(bs)) : 0;
    m_ap = m_a;
    ch[0] = ((FCLK_FRAME >> (4 * m_phase)) & 15) ^ (inj ? 1 : 0);
    for (int l = 0; l < 2; l++) ch[l+1] = int'(({m_w1[l], m_w0[l]} >> (4 * m_phase)) & 20'hF);
    for (int k = 0; k < 3; k++) m_a[k] = en ? ch[k] : 0;
    case (mode)
      2'd0: begin
        s[0] = (rdy && in_valid) ? in_data[9:0]   : IDLE_W;
        s[1] = (rdy && in_valid) ? in_data[19:10] : IDLE_W;
      end
      2'd1: begin s[0] = 10'(m_ramp); s[1] = ~10'(m_ramp); end
      2'd2: begin s[0] = CONST_W;  s[1] = CONST_W;  end
      default: begin s[0] = DESKEW_W; s[1] = DESKEW_W; end
    endcase
    if (sync) begin
      m_w0 = s; m_w1 = s;
      m_phase = 0; m_ramp = 0;
      if (mode == 2'd0) m_uf++;
    end else if (en) begin
      if (m_phase == 4 || m_phase == 1) begin
        if (m_phase == 4) m_w0 = s;
        else              m_w1 = s;
        if (mode == 2'd0 && !in_valid) m_uf++;
        if (mode == 2'd1) m_ramp = (m_ramp + 1) % 1024;
      end
      m_phase = (m_phase + 1) % 5;
    end
  endtask

  // One clock: check the combinational handshake, step, then check registered outputs
  task automatic cyc();
    #2;
    chk("in_ready", 32'(in_ready), 32'(model_ready()));
    @(posedge clk);
    model_step();
    #1;
    chk("fclk4b", 32'(fclk4b), 32'(m_out[0]));
    chk("din4b", 32'(din4b), 32'((m_out[2] << 4) | m_out[1]));
    chk("underflow_cnt", underflow_cnt, 32'(m_uf));
  endtask

  logic [3:0] exp_f[5] = '{4'hF, 4'h1, 4'hC, 4'h7, 4'h0};
  logic [7:0] exp_d[5] = '{8'h55, 8'hAA, 8'h66, 8'h99, 8'hAA};

  initial begin
    int rc;
    rst = 1'b1; en = 1'b0; sync = 1'b0; mode = 2'd2; bs = 2'd0;
    inj = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) cyc();
    chk("reset_fclk", 32'(fclk4b), 32'h0);
    chk("reset_din", 32'(din4b), 32'h0);
    chk("reset_uf", underflow_cnt, 32'h0);

    // First p0 chunk two cycles after reset release
    rst = 1'b0; en = 1'b1;
    cyc();
    chk("post_rst_gap", 32'(fclk4b), 32'h0);
    cyc();
    chk("post_rst_p0", 32'(fclk4b), 32'hF);
    repeat (7) cyc();

    // Constant mode after a mid-frame sync: fixed chunk pattern
    sync = 1'b1; cyc(); sync = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 5; i++) begin
      chk("const_fclk", 32'(fclk4b), 32'(exp_f[i]));
      chk("const_din", 32'(din4b), 32'(exp_d[i]));
      cyc();
    end

    // Stream mode, source always valid: 2 of every 5 cycles ready, no underflow
    mode = 2'd0; in_valid = 1'b1; rc = 0;
    for (int i = 0; i < 25; i++) begin
      in_data = 20'($urandom);
      #1;
      if (in_ready) rc++;
      cyc();
    end
    chk("ready_duty", 32'(rc), 32'd10);
    chk("uf_stream", underflow_cnt, 32'd0);

    // Three starved slots
    in_valid = 1'b0; rc = 0;
    for (int g = 0; g < 20 && rc < 3; g++) begin
      #1;
      if (in_ready) rc++;
      cyc();
    end
    chk("starved_slots", 32'(rc), 32'd3);
    chk("uf_three", underflow_cnt, 32'd3);
    in_valid = 1'b1;
    repeat (10) begin in_data = 20'($urandom); cyc(); end

    // Ramp, then deskew with a 2-bit shift and one injected fclk error
    mode = 2'd1;
    repeat (60) cyc();
    mode = 2'd3; bs = 2'd2;
    repeat (12) cyc();
    inj = 1'b1; cyc(); inj = 1'b0;
    repeat (10) cyc();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      sync     = ($urandom_range(0, 29) == 0);
      inj      = ($urandom_range(0, 9) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 20'($urandom);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 19) == 0) bs   = 2'($urandom);
      cyc();
    end

    // Reset mid-frame
    en = 1'b1; sync = 1'b0; inj = 1'b0; bs = 2'd0; mode = 2'd2;
    repeat (3) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_mid_fclk", 32'(fclk4b), 32'h0);
    chk("rst_mid_din", 32'(din4b), 32'h0);
    cyc(); cyc();
    chk("rst_mid_p0", 32'(fclk4b), 32'hF);
    repeat (10) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
